// File: rtl/ofdm_pkg.sv
// Shared constants and types for the OFDM subcarrier mapper.
// Carrier count, allocation codes and Q3.13 sample constants.
package ofdm_pkg;

  localparam int NCAR = 52;

  localparam logic [1:0] ALLOC_NULL  = 2'b00;
  localparam logic [1:0] ALLOC_DATA  = 2'b01;
  localparam logic [1:0] ALLOC_PILOT = 2'b10;

  localparam logic [15:0] PILOT_AMP = 16'h2000;
  localparam logic [31:0] ZERO_IQ   = 32'h0000_0000;
  localparam logic [6:0]  LFSR_SEED = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT,
    ST_DRAIN
  } state_t;

  function automatic logic [31:0] pilot_iq(input logic p);
    logic [15:0] re;
    re = p ? (16'h0000 - PILOT_AMP) : PILOT_AMP;
    return {16'h0000, re};
  endfunction

endpackage

// File: rtl/pilot_lfsr.sv
// Pilot polarity scrambler, x^7+x^4+1, polarity = bit 6.
// Only present when PILOT_SCRAMBLE_EN is defined; otherwise polarity is 0.
module pilot_lfsr
  import ofdm_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_reseed,
  input  logic i_adv,
  output logic o_p
);

`ifdef PILOT_SCRAMBLE_EN
  logic [6:0] r_lfsr;

  // Reseed wins over advance when both land in one cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_reseed) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_adv) begin
      r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[3]};
    end
  end

  assign o_p = r_lfsr[6];
`else
  logic w_unused;

  assign w_unused = ^{i_clk, i_rst_n, i_reseed, i_adv};
  assign o_p      = 1'b0;
`endif

endmodule

// File: rtl/ofdm_pilot_map.sv
// OFDM transmit subcarrier mapper: data, BPSK pilots and nulls per carrier.
// Optional pilot scrambling: define PILOT_SCRAMBLE_EN.
module ofdm_pilot_map
  import ofdm_pkg::*;
(
  input  logic         CLK_I,
  input  logic         RST_I,
  input  logic [31:0]  DAT_I,
  input  logic         WE_I,
  input  logic         STB_I,
  input  logic         CYC_I,
  output logic         ACK_O,
  output logic [31:0]  DAT_O,
  output logic         CYC_O,
  output logic         STB_O,
  output logic         WE_O,
  input  logic         ACK_I,
  input  logic [103:0] ALLOC_VEC,
  output logic         VEC_LD
);

  state_t r_state;
  state_t w_nxt;

  logic [103:0] r_alloc;
  logic [5:0]   r_car;
  logic [31:0]  r_dat;
  logic         r_stb;
  logic         r_cyc;
  logic         r_cyc_d;

  logic        w_datin_val;
  logic        w_out_halt;
  logic        w_istart;
  logic        w_p;
  logic [1:0]  w_code;
  logic        w_is_data;
  logic        w_is_pilot;
  logic        w_avail;
  logic        w_emit;
  logic        w_step;
  logic        w_last;
  logic        w_adv;
  logic [31:0] w_sample;

  assign w_datin_val = WE_I & STB_I & CYC_I;
  assign w_out_halt  = r_stb & ~ACK_I;
  assign w_istart    = CYC_I & ~r_cyc_d;

  assign w_code     = r_alloc[{r_car, 1'b0} +: 2];
  assign w_is_data  = (w_code == ALLOC_DATA);
  assign w_is_pilot = w_code[1];

  // Once upstream has closed its cycle, data carriers fill with zero
  assign w_avail = ~w_is_data | w_datin_val | ~CYC_I;
  assign w_emit  = (r_state == ST_EMIT);
  assign w_step  = w_emit & ~w_out_halt & w_avail;
  assign w_last  = (r_car == 6'(NCAR - 1));
  assign w_adv   = w_step & w_last;

  assign ACK_O  = w_emit & w_is_data & w_datin_val & ~w_out_halt;
  assign DAT_O  = r_dat;
  assign STB_O  = r_stb;
  assign CYC_O  = r_cyc;
  assign WE_O   = r_cyc;
  assign VEC_LD = (r_state == ST_LOAD);

  pilot_lfsr u_lfsr (
    .i_clk    (CLK_I),
    .i_rst_n  (RST_I),
    .i_reseed (w_istart),
    .i_adv    (w_adv),
    .o_p      (w_p)
  );

  always_comb begin
    w_sample = ZERO_IQ;
    unique case (1'b1)
      w_is_pilot:              w_sample = pilot_iq(w_p);
      w_is_data & w_datin_val: w_sample = DAT_I;
      default:                 w_sample = ZERO_IQ;
    endcase
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_istart | w_datin_val) w_nxt = ST_LOAD;
      end
      ST_LOAD: w_nxt = ST_EMIT;
      ST_EMIT: begin
        if (w_adv) w_nxt = CYC_I ? ST_LOAD : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (~w_out_halt) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state <= ST_IDLE;
      r_alloc <= '0;
      r_car   <= '0;
      r_dat   <= ZERO_IQ;
      r_stb   <= 1'b0;
      r_cyc   <= 1'b0;
      r_cyc_d <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cyc_d <= CYC_I;
      unique case (r_state)
        ST_LOAD: begin
          r_alloc <= ALLOC_VEC;
          r_car   <= '0;
          r_cyc   <= 1'b1;
          if (~w_out_halt) r_stb <= 1'b0;
        end
        ST_EMIT: begin
          if (w_step) begin
            r_dat <= w_sample;
            r_stb <= 1'b1;
            r_car <= w_last ? 6'd0 : r_car + 6'd1;
          end else if (~w_out_halt) begin
            r_stb <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (~w_out_halt) begin
            r_stb <= 1'b0;
            r_cyc <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ofdm_pilot_map.sv
// Self-checking bench for ofdm_pilot_map: random traffic against
// a carrier-layout reference model built from allocation vectors.
module tb_ofdm_pilot_map;

  logic         CLK_I = 1'b0;
  logic         RST_I = 1'b0;
  logic [31:0]  DAT_I = '0;
  logic         WE_I = 1'b0;
  logic         STB_I = 1'b0;
  logic         CYC_I = 1'b0;
  logic         ACK_O;
  logic [31:0]  DAT_O;
  logic         CYC_O;
  logic         STB_O;
  logic         WE_O;
  logic         ACK_I = 1'b1;
  logic [103:0] ALLOC_VEC = '0;
  logic         VEC_LD;

  ofdm_pilot_map dut (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .DAT_I     (DAT_I),
    .WE_I      (WE_I),
    .STB_I     (STB_I),
    .CYC_I     (CYC_I),
    .ACK_O     (ACK_O),
    .DAT_O     (DAT_O),
    .CYC_O     (CYC_O),
    .STB_O     (STB_O),
    .WE_O      (WE_O),
    .ACK_I     (ACK_I),
    .ALLOC_VEC (ALLOC_VEC),
    .VEC_LD    (VEC_LD)
  );

  always #5 CLK_I = ~CLK_I;

  int vec = 0;
  int err = 0;

  logic [31:0]  in_q[$];
  logic [31:0]  out_q[$];
  logic [31:0]  exp_q[$];
  logic [103:0] alloc_q[$];
  int alloc_idx;
  int vld_cnt;
  int nsym_tgt;
  bit cyc_en;
  bit stall_rnd;
  bit bp_rnd;
  int bp_at = -1;
  int bp_left = 0;
  bit hold_pend;
  logic [31:0] hold_dat;
  int hold_bad;
  int ack_bad;
  int halt_cyc;
  int fall_beats;
  bit cyc_prev;
  int wev_bad;

  function automatic logic [103:0] make_layout();
    logic [103:0] a;
    for (int k = 0; k < 52; k++) a[2*k +: 2] = 2'b01;
    a[1:0] = 2'b00;
    a[103:102] = 2'b00;
    a[11:10] = 2'b10;
    a[39:38] = 2'b10;
    a[65:64] = 2'b10;
    a[93:92] = 2'b10;
    return a;
  endfunction

  function automatic logic [103:0] make_random();
    logic [103:0] a;
    int r;
    for (int k = 0; k < 52; k++) begin
      r = $urandom_range(0, 7);
      a[2*k +: 2] = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 :
                    (r == 2) ? 2'b11 : 2'b01;
    end
    r = $urandom_range(0, 2);
    a[103:102] = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b11;
    return a;
  endfunction

  function automatic int count_data();
    int n = 0;
    foreach (alloc_q[j])
      for (int k = 0; k < 52; k++)
        if (alloc_q[j][2*k +: 2] == 2'b01) n++;
    return n;
  endfunction

  // Expected sample stream for one upstream session, starting at seed 7F
  function automatic void build_exp(input logic [31:0] words[$]);
    int w = 0;
    logic [6:0] s = 7'h7F;
    logic [31:0] pil;
    logic [1:0] c;
    exp_q.delete();
    foreach (alloc_q[j]) begin
`ifdef PILOT_SCRAMBLE_EN
      pil = s[6] ? 32'h0000E000 : 32'h00002000;
      s = {s[5:0], s[6] ^ s[3]};
`else
      pil = 32'h00002000;
      s = s;
`endif
      for (int k = 0; k < 52; k++) begin
        c = alloc_q[j][2*k +: 2];
        if (c[1]) exp_q.push_back(pil);
        else if (c[0]) begin
          exp_q.push_back(w < words.size() ? words[w] : 32'h0);
          w++;
        end else exp_q.push_back(32'h0);
      end
    end
  endfunction

  // One clock: observe at negedge, drive #1 after posedge
  task automatic cycle();
    bit vl;
    bit v;
    @(negedge CLK_I);
    if (hold_pend && (STB_O !== 1'b1 || DAT_O !== hold_dat)) hold_bad++;
    hold_pend = (STB_O === 1'b1) && (ACK_I === 1'b0);
    hold_dat = DAT_O;
    if (hold_pend) begin
      halt_cyc++;
      if (ACK_O !== 1'b0) ack_bad++;
    end
    if (WE_O !== CYC_O) wev_bad++;
    if (ACK_O === 1'b1 && in_q.size() > 0) void'(in_q.pop_front());
    if (STB_O === 1'b1 && ACK_I === 1'b1) out_q.push_back(DAT_O);
    vl = (VEC_LD === 1'b1);
    if (vl) vld_cnt++;
    if (cyc_prev && CYC_O === 1'b0) fall_beats = out_q.size();
    cyc_prev = (CYC_O === 1'b1);
    @(posedge CLK_I);
    #1;
    if (vl) begin
      alloc_idx++;
      if (alloc_idx < alloc_q.size()) ALLOC_VEC = alloc_q[alloc_idx];
    end
    if (in_q.size() == 0 && vld_cnt >= nsym_tgt) cyc_en = 0;
    CYC_I = cyc_en;
    v = cyc_en && in_q.size() > 0 &&
        (!stall_rnd || $urandom_range(0, 3) != 0);
    STB_I = v ? 1'b1 : 1'($urandom_range(0, 1));
    WE_I = v;
    DAT_I = v ? in_q[0] : $urandom;
    if (bp_left > 0 && STB_O === 1'b1 && out_q.size() == bp_at) begin
      ACK_I = 1'b0;
      bp_left--;
    end else begin
      ACK_I = bp_rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  endtask

  task automatic start_session(input int nsym);
    vld_cnt = 0; out_q.delete(); fall_beats = -1;
    alloc_idx = 0; ALLOC_VEC = alloc_q[0];
    nsym_tgt = nsym; cyc_en = 1; hold_pend = 0; cyc_prev = 0;
    hold_bad = 0; ack_bad = 0; halt_cyc = 0; wev_bad = 0;
  endtask

  task automatic run_session(input int maxc, output bit tmo);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!(cyc_en == 0 && CYC_O === 1'b0 && STB_O === 1'b0 &&
                 fall_beats >= 0) && n < maxc);
    tmo = (n >= maxc);
    repeat (2) cycle();
  endtask

  task automatic test_reset();
    RST_I = 1'b0;
    repeat (3) @(negedge CLK_I);
    vec++; if (DAT_O !== 32'h0) begin err++;
      $display("FAIL rst_dat: got %h want 0", DAT_O); end
    vec++; if (STB_O !== 1'b0) begin err++;
      $display("FAIL rst_stb: got %b want 0", STB_O); end
    vec++; if (CYC_O !== 1'b0) begin err++;
      $display("FAIL rst_cyc: got %b want 0", CYC_O); end
    vec++; if (ACK_O !== 1'b0) begin err++;
      $display("FAIL rst_ack: got %b want 0", ACK_O); end
    vec++; if (VEC_LD !== 1'b0) begin err++;
      $display("FAIL rst_vecld: got %b want 0", VEC_LD); end
    vec++; if (WE_O !== 1'b0) begin err++;
      $display("FAIL rst_we: got %b want 0", WE_O); end
    RST_I = 1'b1;
    @(posedge CLK_I); #1;
  endtask

  task automatic test_layout();
    logic [31:0] w[$];
    bit tmo;
    alloc_q = '{make_layout()};
    for (int i = 1; i <= count_data(); i++) w.push_back({16'(i), 16'(i)});
    build_exp(w);
    in_q = w; stall_rnd = 0; bp_rnd = 0; bp_left = 0;
    start_session(1);
    run_session(300, tmo);
    vec++; if (tmo) begin err++;
      $display("FAIL layout_timeout: got timeout want done"); end
    vec++; if (out_q.size() != exp_q.size()) begin err++;
      $display("FAIL layout_beats: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vec++; if (out_q[i] !== exp_q[i]) begin err++;
        $display("FAIL layout_car%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    vec++; if (vld_cnt != 1) begin err++;
      $display("FAIL layout_vecld: got %0d want 1", vld_cnt); end
    vec++; if (wev_bad != 0) begin err++;
      $display("FAIL layout_we_o: got %0d mismatches want 0", wev_bad); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[$];
    bit tmo;
    alloc_q = '{make_layout()};
    for (int i = 0; i < count_data(); i++) w.push_back($urandom);
    build_exp(w);
    in_q = w; stall_rnd = 1; bp_rnd = 0;
    start_session(1);
    bp_at = 10; bp_left = 3;
    run_session(400, tmo);
    vec++; if (tmo) begin err++;
      $display("FAIL bp_timeout: got timeout want done"); end
    vec++; if (out_q.size() != exp_q.size()) begin err++;
      $display("FAIL bp_beats: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vec++; if (out_q[i] !== exp_q[i]) begin err++;
        $display("FAIL bp_car%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    vec++; if (halt_cyc != 3) begin err++;
      $display("FAIL bp_halt_cycles: got %0d want 3", halt_cyc); end
    vec++; if (hold_bad != 0) begin err++;
      $display("FAIL bp_dat_hold: got %0d changes want 0", hold_bad); end
    vec++; if (ack_bad != 0) begin err++;
      $display("FAIL bp_ack_in_halt: got %0d want 0", ack_bad); end
    bp_at = -1; bp_left = 0;
  endtask

  task automatic test_underrun();
    logic [31:0] w[$];
    bit tmo;
    alloc_q = '{make_layout()};
    for (int i = 0; i < 20; i++) w.push_back($urandom | 32'h1);
    build_exp(w);
    in_q = w; stall_rnd = 1; bp_rnd = 1;
    start_session(1);
    run_session(400, tmo);
    vec++; if (tmo) begin err++;
      $display("FAIL under_timeout: got timeout want done"); end
    vec++; if (out_q.size() != 52) begin err++;
      $display("FAIL under_beats: got %0d want 52", out_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vec++; if (out_q[i] !== exp_q[i]) begin err++;
        $display("FAIL under_car%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    vec++; if (fall_beats != 52) begin err++;
      $display("FAIL under_cyc_fall: got %0d beats at fall want 52", fall_beats); end
    vec++; if (hold_bad != 0 || ack_bad != 0) begin err++;
      $display("FAIL under_halt: got hold=%0d ack=%0d want 0", hold_bad, ack_bad); end
  endtask

  task automatic test_pilot_polarity();
    logic [31:0] w[$];
    bit tmo;
    alloc_q.delete();
    repeat (8) alloc_q.push_back(make_layout());
    for (int i = 0; i < count_data(); i++) w.push_back($urandom);
    build_exp(w);
    in_q = w; stall_rnd = 0; bp_rnd = 0;
    start_session(8);
    run_session(1200, tmo);
    vec++; if (tmo) begin err++;
      $display("FAIL pol_timeout: got timeout want done"); end
    vec++; if (vld_cnt != 8) begin err++;
      $display("FAIL pol_vecld: got %0d want 8", vld_cnt); end
    vec++; if (out_q.size() != exp_q.size()) begin err++;
      $display("FAIL pol_beats: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vec++; if (out_q[i] !== exp_q[i]) begin err++;
        $display("FAIL pol_car%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[$];
    bit tmo;
    alloc_q.delete();
    repeat (4) alloc_q.push_back(make_random());
    for (int i = 0; i < count_data(); i++) w.push_back($urandom);
    build_exp(w);
    in_q = w; stall_rnd = 1; bp_rnd = 1;
    start_session(4);
    run_session(2000, tmo);
    vec++; if (tmo) begin err++;
      $display("FAIL b2b_timeout: got timeout want done"); end
    vec++; if (vld_cnt != 4) begin err++;
      $display("FAIL b2b_vecld: got %0d want 4", vld_cnt); end
    vec++; if (out_q.size() != exp_q.size()) begin err++;
      $display("FAIL b2b_beats: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vec++; if (out_q[i] !== exp_q[i]) begin err++;
        $display("FAIL b2b_car%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    vec++; if (hold_bad != 0 || ack_bad != 0) begin err++;
      $display("FAIL b2b_halt: got hold=%0d ack=%0d want 0", hold_bad, ack_bad); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] w[$];
    bit tmo;
    int n = 0;
    alloc_q = '{make_layout(), make_layout()};
    for (int i = 0; i < count_data(); i++) w.push_back($urandom);
    in_q = w; stall_rnd = 0; bp_rnd = 0;
    start_session(2);
    while (out_q.size() < 82 && n < 400) begin cycle(); n++; end
    vec++; if (n >= 400) begin err++;
      $display("FAIL abort_reach: got %0d beats want 82", out_q.size()); end
    #2 RST_I = 1'b0;
    #1;
    vec++; if ({DAT_O, STB_O, CYC_O, ACK_O, VEC_LD} !== 36'h0) begin err++;
      $display("FAIL abort_outs: got dat=%h stb=%b cyc=%b ack=%b vld=%b want 0",
               DAT_O, STB_O, CYC_O, ACK_O, VEC_LD); end
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ACK_I = 1'b1;
    in_q.delete();
    repeat (2) @(posedge CLK_I);
    #3 RST_I = 1'b1;
    @(posedge CLK_I); #1;
    alloc_q = '{make_layout()};
    w.delete();
    for (int i = 0; i < count_data(); i++) w.push_back($urandom);
    build_exp(w);
    in_q = w;
    start_session(1);
    run_session(300, tmo);
    vec++; if (tmo) begin err++;
      $display("FAIL abort_timeout: got timeout want done"); end
    vec++; if (out_q.size() != 52) begin err++;
      $display("FAIL abort_beats: got %0d want 52", out_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vec++; if (out_q[i] !== exp_q[i]) begin err++;
        $display("FAIL abort_car%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_layout();
    test_backpressure();
    test_underrun();
    test_pilot_polarity();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
